// File: rtl/fetch_pkg.sv
// Shared definitions for the instFetch stage: internal op codes, RV32I
// opcode field values, the 55-bit decoded-op record and the fetcher states.
package fetch_pkg;

  // Internal op codes; 0 is the bubble/NOP marker.
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LUI   = 5'd1;
  localparam logic [4:0] OP_AUIPC = 5'd2;
  localparam logic [4:0] OP_JAL   = 5'd3;
  localparam logic [4:0] OP_JALR  = 5'd4;
  localparam logic [4:0] OP_BEQ   = 5'd5;
  localparam logic [4:0] OP_BNE   = 5'd6;
  localparam logic [4:0] OP_BLT   = 5'd7;
  localparam logic [4:0] OP_BGE   = 5'd8;
  localparam logic [4:0] OP_BLTU  = 5'd9;
  localparam logic [4:0] OP_BGEU  = 5'd10;
  localparam logic [4:0] OP_LB    = 5'd11;
  localparam logic [4:0] OP_LH    = 5'd12;
  localparam logic [4:0] OP_LW    = 5'd13;
  localparam logic [4:0] OP_LBU   = 5'd14;
  localparam logic [4:0] OP_LHU   = 5'd15;
  localparam logic [4:0] OP_SB    = 5'd16;
  localparam logic [4:0] OP_SH    = 5'd17;
  localparam logic [4:0] OP_SW    = 5'd18;
  // ALU ops are laid out in funct3 order so ADD + funct3 selects them;
  // the immediate forms reuse the same codes with use_imm set.
  localparam logic [4:0] OP_ADD   = 5'd19;
  localparam logic [4:0] OP_SLL   = 5'd20;
  localparam logic [4:0] OP_SLT   = 5'd21;
  localparam logic [4:0] OP_SLTU  = 5'd22;
  localparam logic [4:0] OP_XOR   = 5'd23;
  localparam logic [4:0] OP_SRL   = 5'd24;
  localparam logic [4:0] OP_OR    = 5'd25;
  localparam logic [4:0] OP_AND   = 5'd26;
  localparam logic [4:0] OP_SUB   = 5'd27;
  localparam logic [4:0] OP_SRA   = 5'd28;

  // RV32I major opcode field values.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int REC_W = 55;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        branch;
    logic        ls;
    logic        use_imm;
  } op_rec_t;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_JSTALL = 2'd3
  } fetch_state_t;

  function automatic logic [4:0] alu_op(input logic [2:0] f3);
    return OP_ADD + {2'b00, f3};
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I decoder: one instruction word in, one op record out.
// Anything illegal or unsupported comes out as an all-zero (bubble) record.
module inst_decoder
  import fetch_pkg::*;
(
  input  logic [31:0] word,
  output op_rec_t     rec
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  op;

  assign f3    = word[14:12];
  assign f7    = word[31:25];
  assign imm_i = {{20{word[31]}}, word[31:20]};
  assign imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
  assign imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
  assign imm_u = {word[31:12], 12'b0};
  assign imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

  // Pick the op code and fill only the fields that format uses.
  always_comb begin
    rec = '0;
    op  = OP_NOP;
    case (word[6:0])
      OPC_LUI, OPC_AUIPC: begin
        op          = (word[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
        rec.rd      = word[11:7];
        rec.imm     = imm_u;
        rec.use_imm = 1'b1;
      end
      OPC_JAL: begin
        op      = OP_JAL;
        rec.rd  = word[11:7];
        rec.imm = imm_j;
      end
      OPC_JALR: begin
        op          = (f3 == 3'b000) ? OP_JALR : OP_NOP;
        rec.rd      = word[11:7];
        rec.rs1     = word[19:15];
        rec.imm     = imm_i;
        rec.use_imm = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_NOP;
        endcase
        rec.rs1    = word[19:15];
        rec.rs2    = word[24:20];
        rec.imm    = imm_b;
        rec.branch = 1'b1;
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_NOP;
        endcase
        rec.rd      = word[11:7];
        rec.rs1     = word[19:15];
        rec.imm     = imm_i;
        rec.ls      = 1'b1;
        rec.use_imm = 1'b1;
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_NOP;
        endcase
        rec.rs1     = word[19:15];
        rec.rs2     = word[24:20];
        rec.imm     = imm_s;
        rec.ls      = 1'b1;
        rec.use_imm = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)
          op = (f7 == 7'b0000000) ? OP_SLL : OP_NOP;
        else if (f3 == 3'b101)
          op = (f7 == 7'b0000000) ? OP_SRL : (f7 == 7'b0100000) ? OP_SRA : OP_NOP;
        else
          op = alu_op(f3);
        rec.rd      = word[11:7];
        rec.rs1     = word[19:15];
        rec.imm     = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, word[24:20]} : imm_i;
        rec.use_imm = 1'b1;
      end
      OPC_OP: begin
        if (f7 == 7'b0000000)
          op = alu_op(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          op = OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          op = OP_SRA;
        else
          op = OP_NOP;
        rec.rd  = word[11:7];
        rec.rs1 = word[19:15];
        rec.rs2 = word[24:20];
      end
      default: op = OP_NOP;
    endcase
    rec.op = op;
    if (op == OP_NOP)
      rec = '0;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Producer end of the decoded-op queue: holds the PC, issues single
// outstanding word fetches, decodes the reply and pushes it under full_in.
// Optional feature macro: FETCH_JAL_FOLD_EN (JAL resolved here, no stall).
module inst_fetcher
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OP_W     = 5
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic            icache_req_out,
  output logic [31:0]     icache_addr_out,
  input  logic            icache_valid_in,
  input  logic [31:0]     icache_data_in,
  input  logic            full_in,
  input  logic            redirect_in,
  input  logic [31:0]     redirect_pc_in,
  output logic [OP_W-1:0] op_out,
  output logic [4:0]      rd_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [31:0]     imm_out,
  output logic            branch_out,
  output logic            ls_out,
  output logic            use_imm_out,
  output logic            stalled_out
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  op_rec_t      hold, hold_nxt, dec;
  logic         hold_valid, hold_valid_nxt;
  logic         discard, discard_nxt;
  logic         push;

  inst_decoder u_dec (
    .word (icache_data_in),
    .rec  (dec)
  );

  assign push = hold_valid & ~full_in;

  // State register; rdy_in low freezes everything, reset always wins.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold       <= '0;
      hold_valid <= 1'b0;
      discard    <= 1'b0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold       <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      discard    <= discard_nxt;
    end
  end

  // Next-state logic; a redirect is applied last so it overrides the FSM,
  // while a push in the same cycle still clears the held record.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    discard_nxt    = discard;

    case (state)
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        if (icache_valid_in) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            hold_nxt       = dec;
            hold_valid_nxt = 1'b1;
            state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (push) begin
          hold_valid_nxt = 1'b0;
          if (hold.op == OP_JALR) begin
            state_nxt = S_JSTALL;
          end else if (hold.op == OP_JAL) begin
`ifdef FETCH_JAL_FOLD_EN
            pc_nxt    = pc + hold.imm;
            state_nxt = S_REQ;
`else
            state_nxt = S_JSTALL;
`endif
          end else begin
            pc_nxt    = pc + 32'd4;
            state_nxt = S_REQ;
          end
        end
      end
      S_JSTALL: state_nxt = S_JSTALL;
      default:  state_nxt = S_REQ;
    endcase

    if (redirect_in) begin
      pc_nxt         = redirect_pc_in;
      hold_valid_nxt = 1'b0;
      if (state == S_REQ) begin
        // The strobe is going out to the old pc; wait for and drop its reply.
        discard_nxt = 1'b1;
        state_nxt   = S_WAIT;
      end else if (state == S_WAIT && !icache_valid_in) begin
        discard_nxt = 1'b1;
        state_nxt   = S_WAIT;
      end else begin
        // Either nothing is outstanding or the stale reply lands right now.
        discard_nxt = 1'b0;
        state_nxt   = S_REQ;
      end
    end
  end

  assign icache_req_out  = (state == S_REQ) && rdy_in && !rst_in;
  assign icache_addr_out = {pc[31:2], 2'b00};
  assign stalled_out     = (state == S_JSTALL);

  assign op_out      = hold_valid ? OP_W'(hold.op) : '0;
  assign rd_out      = hold_valid ? hold.rd        : '0;
  assign rs1_out     = hold_valid ? hold.rs1       : '0;
  assign rs2_out     = hold_valid ? hold.rs2       : '0;
  assign imm_out     = hold_valid ? hold.imm       : '0;
  assign branch_out  = hold_valid & hold.branch;
  assign ls_out      = hold_valid & hold.ls;
  assign use_imm_out = hold_valid & hold.use_imm;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboarded bench for inst_fetcher: an instruction-cache model answers
// requests from a sparse memory, expected requests and pushes are queued by
// each scenario and compared as the DUT produces them.
module tb_inst_fetcher;
  import fetch_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        icache_req_out;
  logic [31:0] icache_addr_out;
  logic        icache_valid_in = 1'b0;
  logic [31:0] icache_data_in = 32'h0;
  logic        full_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic [4:0]  op_out, rd_out, rs1_out, rs2_out;
  logic [31:0] imm_out;
  logic        branch_out, ls_out, use_imm_out, stalled_out;

  inst_fetcher #(.RESET_PC(32'h0), .OP_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_out(icache_req_out), .icache_addr_out(icache_addr_out),
    .icache_valid_in(icache_valid_in), .icache_data_in(icache_data_in),
    .full_in(full_in), .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .op_out(op_out), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .branch_out(branch_out), .ls_out(ls_out),
    .use_imm_out(use_imm_out), .stalled_out(stalled_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
  } exp_t;

  exp_t        exp_ops[$];
  logic [31:0] exp_reqs[$];
  logic [31:0] mem [logic [31:0]];
  int          compared = 0;
  int          mismatched = 0;
  int          lat = 2;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Instruction-cache model: single reply after lat cycles, flags overlap.
  logic        req_smp, rst_smp, pending = 1'b0;
  logic [31:0] addr_smp, pend_addr;
  int          cnt;
  always @(posedge clk_in) begin
    req_smp  = icache_req_out;
    addr_smp = icache_addr_out;
    rst_smp  = rst_in;
    #1;
    icache_valid_in = 1'b0;
    icache_data_in  = 32'h0;
    if (rst_smp) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (cnt <= 1) begin
          icache_valid_in = 1'b1;
          icache_data_in  = mem.exists(pend_addr) ? mem[pend_addr] : enc_jalr(5'd0, 5'd0, 32'd0);
          pending = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (req_smp) begin
        compared++;
        if (pending) begin
          mismatched++;
          $display("[TB] FAIL one_outstanding: request addr=%h while addr=%h still pending", addr_smp, pend_addr);
        end
        pending   = 1'b1;
        pend_addr = addr_smp;
        cnt       = lat;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  logic        prev_push = 1'b0;
  logic        now_push;
  logic [31:0] er;
  exp_t        eo;
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_push = 1'b0;
    end else begin
      if (icache_req_out) begin
        compared++;
        if (exp_reqs.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL req_addr: got unexpected request addr=%h", icache_addr_out);
        end else begin
          er = exp_reqs.pop_front();
          if (icache_addr_out !== er) begin
            mismatched++;
            $display("[TB] FAIL req_addr: got %h expected %h", icache_addr_out, er);
          end
        end
      end
      if (prev_push) begin
        compared++;
        if (op_out !== 5'd0) begin
          mismatched++;
          $display("[TB] FAIL op_gap: op_out=%0d after push, expected 0", op_out);
        end
      end
      now_push = rdy_in && !full_in && (op_out != 5'd0);
      if (now_push) begin
        compared++;
        if (exp_ops.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL push: got unexpected op=%0d rd=%0d imm=%h", op_out, rd_out, imm_out);
        end else begin
          eo = exp_ops.pop_front();
          if (op_out !== eo.op || rd_out !== eo.rd || imm_out !== eo.imm || use_imm_out !== eo.use_imm) begin
            mismatched++;
            $display("[TB] FAIL push: got op=%0d rd=%0d imm=%h use_imm=%b expected op=%0d rd=%0d imm=%h use_imm=%b",
                     op_out, rd_out, imm_out, use_imm_out, eo.op, eo.rd, eo.imm, eo.use_imm);
          end
        end
      end
      prev_push = now_push;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic put_addi(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] imm);
    exp_t x;
    mem[addr] = enc_addi(rd, 5'd0, imm);
    exp_reqs.push_back(addr);
    x.op = OP_ADD; x.rd = rd; x.imm = imm; x.use_imm = 1'b1;
    exp_ops.push_back(x);
  endtask

  task automatic put_jalr(input logic [31:0] addr, input logic [4:0] rs1);
    exp_t x;
    mem[addr] = enc_jalr(5'd0, rs1, 32'd0);
    exp_reqs.push_back(addr);
    x.op = OP_JALR; x.rd = 5'd0; x.imm = 32'd0; x.use_imm = 1'b1;
    exp_ops.push_back(x);
  endtask

  task automatic wait_stall(input int budget);
    for (int i = 0; i < budget && stalled_out !== 1'b1; i++) step();
  endtask

  task automatic wait_held(input int budget);
    for (int i = 0; i < budget && op_out == 5'd0; i++) step();
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_in    = 1'b1;
    redirect_pc_in = target;
    step();
    redirect_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; full_in = 1'b0; redirect_in = 1'b0;
    step();
    step();
    compared++;
    if (op_out !== 5'd0 || imm_out !== 32'd0 || use_imm_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_record: op=%0d imm=%h use_imm=%b expected all 0", op_out, imm_out, use_imm_out);
    end
    compared++;
    if (icache_req_out !== 1'b0 || stalled_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: req=%b stalled=%b expected 0/0", icache_req_out, stalled_out);
    end
    compared++;
    if (icache_addr_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_pc: addr=%h expected 00000000", icache_addr_out);
    end
  endtask

  task automatic test_straight();
    mem.delete();
    lat = 2;
    put_addi(32'h0, 5'd1, 32'd5);
    put_addi(32'h4, 5'd2, 32'hFFFF_FFFD);
    put_addi(32'h8, 5'd3, 32'h0000_07FF);
    put_jalr(32'hC, 5'd1);
    do_reset();
    wait_stall(200);
    compared++;
    if (stalled_out !== 1'b1 || exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL straight_drain: stalled=%b reqs_left=%0d ops_left=%0d expected 1/0/0",
               stalled_out, exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  task automatic test_back_pressure();
    mem.delete();
    put_addi(32'h0, 5'd4, 32'h0000_0123);
    put_jalr(32'h4, 5'd0);
    full_in = 1'b1;
    do_reset();
    wait_held(50);
    compared++;
    if (op_out !== OP_ADD) begin
      mismatched++;
      $display("[TB] FAIL bp_held: op=%0d expected %0d", op_out, OP_ADD);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if (op_out !== OP_ADD || rd_out !== 5'd4 || icache_req_out !== 1'b0 || icache_addr_out !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL bp_stable: op=%0d rd=%0d req=%b addr=%h expected %0d/4/0/00000000",
                 op_out, rd_out, icache_req_out, icache_addr_out, OP_ADD);
      end
    end
    full_in = 1'b0;
    step();
    compared++;
    if (op_out !== 5'd0 || icache_req_out !== 1'b1 || icache_addr_out !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL bp_release: op=%0d req=%b addr=%h expected 0/1/00000004", op_out, icache_req_out, icache_addr_out);
    end
    wait_stall(200);
    compared++;
    if (exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL bp_drain: reqs_left=%0d ops_left=%0d expected 0/0", exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  task automatic test_jalr();
    int bad;
    mem.delete();
    for (int i = 0; i < 4; i++) put_addi(32'(i * 4), 5'(i + 1), 32'(i * 16));
    put_jalr(32'h10, 5'd1);
    put_jalr(32'h200, 5'd0);
    do_reset();
    wait_stall(300);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (icache_req_out !== 1'b0 || stalled_out !== 1'b1) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL jalr_stall: %0d cycles with request or no stall, expected 0", bad);
    end
    pulse_redirect(32'h200);
    compared++;
    if (stalled_out !== 1'b0 || icache_req_out !== 1'b1 || icache_addr_out !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL jalr_redirect: stalled=%b req=%b addr=%h expected 0/1/00000200",
               stalled_out, icache_req_out, icache_addr_out);
    end
    wait_stall(100);
    compared++;
    if (exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL jalr_drain: reqs_left=%0d ops_left=%0d expected 0/0", exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  task automatic test_redirect_mid();
    int early;
    mem.delete();
    lat = 6;
    mem[32'h0] = enc_addi(5'd5, 5'd0, 32'h55);
    exp_reqs.push_back(32'h0);
    put_addi(32'h80, 5'd6, 32'h80);
    put_jalr(32'h84, 5'd0);
    do_reset();
    step();
    pulse_redirect(32'h80);
    early = 0;
    for (int i = 0; i < 20 && icache_valid_in !== 1'b1; i++) begin
      if (icache_req_out === 1'b1) early++;
      step();
    end
    compared++;
    if (early != 0 || icache_valid_in !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_wait: early_reqs=%0d stale_valid=%b expected 0/1", early, icache_valid_in);
    end
    step();
    compared++;
    if (op_out !== 5'd0 || icache_req_out !== 1'b1 || icache_addr_out !== 32'h80) begin
      mismatched++;
      $display("[TB] FAIL mid_drop: op=%0d req=%b addr=%h expected 0/1/00000080", op_out, icache_req_out, icache_addr_out);
    end
    wait_stall(200);
    lat = 2;
    compared++;
    if (exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_drain: reqs_left=%0d ops_left=%0d expected 0/0", exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  task automatic test_jal();
    exp_t x;
    int   stalls;
    logic seen;
    mem.delete();
    for (int i = 0; i < 8; i++) put_addi(32'(i * 4), 5'(i + 8), 32'(i));
    mem[32'h20] = enc_jal(5'd1, 32'h40);
    exp_reqs.push_back(32'h20);
    x.op = OP_JAL; x.rd = 5'd1; x.imm = 32'h40; x.use_imm = 1'b0;
    exp_ops.push_back(x);
    put_jalr(32'h60, 5'd0);
    do_reset();
`ifdef FETCH_JAL_FOLD_EN
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (stalled_out === 1'b1) stalls++;
      if (icache_req_out === 1'b1 && icache_addr_out === 32'h60) seen = 1'b1;
      else step();
    end
    compared++;
    if (!seen || stalls != 0) begin
      mismatched++;
      $display("[TB] FAIL jal_fold: target_seen=%b stall_cycles=%0d expected 1/0", seen, stalls);
    end
`else
    wait_stall(300);
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (stalled_out === 1'b1 && icache_req_out === 1'b0) stalls++;
    end
    compared++;
    if (stalls != 5) begin
      mismatched++;
      $display("[TB] FAIL jal_stall: stalled idle cycles=%0d expected 5", stalls);
    end
    pulse_redirect(32'h60);
    seen = (icache_req_out === 1'b1 && icache_addr_out === 32'h60);
    compared++;
    if (!seen || stalled_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL jal_redirect: req=%b addr=%h stalled=%b expected 1/00000060/0",
               icache_req_out, icache_addr_out, stalled_out);
    end
`endif
    wait_stall(100);
    compared++;
    if (exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL jal_drain: reqs_left=%0d ops_left=%0d expected 0/0", exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  task automatic test_rdy();
    mem.delete();
    put_addi(32'h0, 5'd7, 32'hFFFF_F800);
    put_jalr(32'h4, 5'd0);
    full_in = 1'b1;
    do_reset();
    wait_held(50);
    rdy_in  = 1'b0;
    full_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (op_out !== OP_ADD || rd_out !== 5'd7 || imm_out !== 32'hFFFF_F800 || icache_req_out !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rdy_freeze: op=%0d rd=%0d imm=%h req=%b expected %0d/7/fffff800/0",
                 op_out, rd_out, imm_out, icache_req_out, OP_ADD);
      end
    end
    rdy_in = 1'b1;
    step();
    compared++;
    if (op_out !== 5'd0 || icache_req_out !== 1'b1 || icache_addr_out !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL rdy_resume: op=%0d req=%b addr=%h expected 0/1/00000004", op_out, icache_req_out, icache_addr_out);
    end
    wait_stall(100);
    compared++;
    if (exp_reqs.size() != 0 || exp_ops.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rdy_drain: reqs_left=%0d ops_left=%0d expected 0/0", exp_reqs.size(), exp_ops.size());
      exp_reqs.delete(); exp_ops.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_straight();
    test_back_pressure();
    test_jalr();
    test_redirect_mid();
    test_jal();
    test_rdy();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
